// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and control FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_XOR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; master drives requests and
// consumes results, slave is the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  opcode_e          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic             flag_c;
  logic             flag_z;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_hi, flag_c, flag_z
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_hi, flag_c, flag_z
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle: bit 0 is folded in
// on the start edge, done pulses the cycle the full product sits in product.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      // Consuming b[0] on the load edge leaves WIDTH-1 busy steps, so the
      // product is final one cycle earlier and the top can register it.
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops give out_valid 1 cycle after accept, MUL after WIDTH+1;
// result holds until out_ready, and a new request is taken in the same cycle it drains.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   y_q,     y_d;
  logic [WIDTH-1:0]   y_hi_q,  y_hi_d;
  logic               c_q,     c_d;
  logic               z_q,     z_d;

  logic               in_ready;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    shamt = bus.b[SHW-1:0];
    alu_y = '0;
    alu_c = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the borrow.
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
      end
      OP_MUL: alu_y = '0;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_SHL: alu_y = bus.a << shamt;
      OP_SHR: alu_y = bus.a >> shamt;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = !mul_busy;
      BUSY:    in_ready = 1'b0;
      DONE:    in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_hi_d    = y_hi_q;
    c_d       = c_q;
    z_d       = z_q;
    mul_start = 1'b0;
    if (accept) begin
      if (bus.op == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = BUSY;
      end else begin
        state_d = DONE;
        y_d     = alu_y;
        y_hi_d  = '0;
        c_d     = alu_c;
        z_d     = (alu_y == '0);
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (mul_done) begin
            state_d = DONE;
            y_d     = mul_product[WIDTH-1:0];
            y_hi_d  = mul_product[2*WIDTH-1:WIDTH];
            c_d     = 1'b0;
            z_d     = (mul_product == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      y_hi_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
  assign bus.y_hi      = y_hi_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_z    = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: inputs change 1 time unit after the rising
// edge and outputs are sampled then, with expected values worked out by hand.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input opcode_e o, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int busy_cycles;
    int seen;

    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y",         32'(bus.y),         32'h00);
    check("rst_y_hi",      32'(bus.y_hi),      32'h00);
    check("rst_flag_c",    32'(bus.flag_c),    32'd0);
    check("rst_flag_z",    32'(bus.flag_z),    32'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD with carry, result held while consumer stalls
    drive(1'b1, OP_ADD, 8'hF0, 8'h20);
    step();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    check("add_out_valid", 32'(bus.out_valid), 32'd1);
    check("add_y",         32'(bus.y),         32'h10);
    check("add_flag_c",    32'(bus.flag_c),    32'd1);
    check("add_flag_z",    32'(bus.flag_z),    32'd0);
    check("add_y_hi",      32'(bus.y_hi),      32'h00);
    check("add_in_ready",  32'(bus.in_ready),  32'd0);
    bus.out_ready = 1'b1;
    step();
    check("add_drained", 32'(bus.out_valid), 32'd0);

    // SUB back-to-back: zero result then borrow, no idle cycle
    drive(1'b1, OP_SUB, 8'h05, 8'h05);
    step();
    check("sub0_out_valid", 32'(bus.out_valid), 32'd1);
    check("sub0_y",         32'(bus.y),         32'h00);
    check("sub0_flag_z",    32'(bus.flag_z),    32'd1);
    check("sub0_flag_c",    32'(bus.flag_c),    32'd0);
    check("sub0_in_ready",  32'(bus.in_ready),  32'd1);
    drive(1'b1, OP_SUB, 8'h03, 8'h04);
    step();
    check("sub1_out_valid", 32'(bus.out_valid), 32'd1);
    check("sub1_y",         32'(bus.y),         32'hFF);
    check("sub1_flag_c",    32'(bus.flag_c),    32'd1);
    check("sub1_flag_z",    32'(bus.flag_z),    32'd0);
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    step();
    check("sub_drained", 32'(bus.out_valid), 32'd0);

    // MUL 0xFF*0xFF = 0xFE01; operands scrambled after accept
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF);
    step();
    drive(1'b0, OP_XOR, 8'h33, 8'h77);
    lat = 1;
    busy_cycles = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (bus.in_ready === 1'b0) busy_cycles++;
      step();
      lat++;
    end
    check("mul_latency",     32'(lat),         32'd9);
    check("mul_busy_cycles", 32'(busy_cycles), 32'd8);
    check("mul_y",           32'(bus.y),       32'h01);
    check("mul_y_hi",        32'(bus.y_hi),    32'hFE);
    check("mul_flag_z",      32'(bus.flag_z),  32'd0);
    check("mul_flag_c",      32'(bus.flag_c),  32'd0);
    step();
    check("mul_drained", 32'(bus.out_valid), 32'd0);

    // XOR held under 5 cycles of backpressure; queued OR request must wait
    bus.out_ready = 1'b0;
    drive(1'b1, OP_XOR, 8'hA5, 8'h5A);
    step();
    drive(1'b1, OP_OR, 8'h0F, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      check("xor_hold_y",         32'(bus.y),         32'hFF);
      check("xor_hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("xor_hold_in_ready",  32'(bus.in_ready),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("xor_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("xor_release_y",        32'(bus.y),        32'hFF);
    step();
    check("or_y",         32'(bus.y),         32'hFF);
    check("or_flag_z",    32'(bus.flag_z),    32'd0);
    check("or_out_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    step();
    check("or_drained", 32'(bus.out_valid), 32'd0);

    // MUL aborted by reset three cycles after accept
    drive(1'b1, OP_MUL, 8'h12, 8'h34);
    step();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_y",         32'(bus.y),         32'h00);
    check("abort_y_hi",      32'(bus.y_hi),      32'h00);
    check("abort_flag_c",    32'(bus.flag_c),    32'd0);
    check("abort_flag_z",    32'(bus.flag_z),    32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    seen = 0;
    repeat (15) begin
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // Reset while a result is waiting in DONE discards it
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'h01, 8'h02);
    step();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    check("done_rst_pre_valid", 32'(bus.out_valid), 32'd1);
    check("done_rst_pre_y",     32'(bus.y),         32'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("done_rst_valid", 32'(bus.out_valid), 32'd0);
    check("done_rst_y",     32'(bus.y),         32'h00);
    step();
    check("done_rst_stays_idle", 32'(bus.out_valid), 32'd0);

    // Shifts, shift amount masked to low 3 bits
    bus.out_ready = 1'b1;
    drive(1'b1, OP_SHL, 8'h81, 8'h01);
    step();
    check("shl_y",         32'(bus.y),         32'h02);
    check("shl_flag_c",    32'(bus.flag_c),    32'd0);
    check("shl_out_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b1, OP_SHR, 8'h81, 8'h09);
    step();
    check("shr_y", 32'(bus.y), 32'h40);
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    step();

    // MUL 0x12*0x34 = 0x03A8 runs to completion
    drive(1'b1, OP_MUL, 8'h12, 8'h34);
    step();
    drive(1'b0, OP_ADD, 8'h00, 8'h00);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("mul2_latency", 32'(lat),      32'd9);
    check("mul2_y",       32'(bus.y),    32'hA8);
    check("mul2_y_hi",    32'(bus.y_hi), 32'h03);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width; legal values 4..32.
REQ-002 SHALL have clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  operation request valid.
REQ-005 SHALL have in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have a, b  input  WIDTH each  operands.
REQ-007 SHALL have op  input  opcode_e (3 bits)  operation select.
REQ-008 SHALL have out_valid  output  1  result valid.
REQ-009 SHALL have out_ready  input  1  consumer accepts result.
REQ-010 SHALL have y  output  WIDTH  result, or low half of product.
REQ-011 SHALL have y_hi  output  WIDTH  high half of product; 0 for non-MUL.
REQ-012 SHALL have flag_c  output  1  ADD carry-out / SUB borrow; 0 otherwise.
REQ-013 SHALL have flag_z  output  1  y == 0 (MUL: full product == 0).

Function
REQ-014 Opcodes SHALL be ADD=0, SUB=1, MUL=2, XOR=3, AND=4, OR=5, SHL=6, SHR=7.
REQ-015 Arithmetic SHALL be unsigned modulo 2^WIDTH; SHL/SHR shift a by b[$clog2(WIDTH)-1:0], zero fill.
REQ-016 Request SHALL be accepted on a cycle with in_valid && in_ready; a, b, op captured that edge.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE + accept non-MUL -> DONE; result registered; out_valid high next cycle (latency 1).
REQ-019 IDLE + accept MUL -> BUSY; iterative shift-add, one multiplier bit per cycle, WIDTH cycles; BUSY -> DONE after last step; out_valid high WIDTH+1 cycles after accept.
REQ-020 DONE: out_valid=1; y, y_hi, flags SHALL hold stable until out_valid && out_ready.
REQ-021 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal out_ready in DONE.
REQ-022 DONE with out_ready and no new accept -> IDLE.
REQ-023 DONE with out_ready and simultaneous accept -> DONE (non-MUL) or BUSY (MUL), giving back-to-back non-MUL throughput of one per cycle.
REQ-024 in_valid while in_ready=0 SHALL be ignored; no input buffering.
REQ-025 Operand changes after accept SHALL NOT affect the in-flight result.
REQ-026 op values outside enum are impossible (3-bit fully decoded); no default error path.

Reset
REQ-027 rst SHALL force state IDLE, out_valid=0, y=0, y_hi=0, flag_c=0, flag_z=0, multiplier counter and accumulator 0.
REQ-028 rst asserted mid-MUL or in DONE SHALL discard the operation; no result is ever presented for it.
REQ-029 in_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-030 Package alu_pkg SHALL hold opcode_e (3-bit enum, REQ-014) and state enum state_e; module imports alu_pkg.
REQ-031 Iterative multiplier SHALL be sub-module alu_mul_iter (parameter WIDTH; start, a, b in; busy, done, product[2*WIDTH-1:0] out).
REQ-032 No latches; all state in one always_ff on clk; next-state/ALU logic in always_comb.

Verification (WIDTH=8)
REQ-033 ADD a=0xF0 b=0x20 -> next cycle out_valid=1, y=0x10, flag_c=1, flag_z=0.
REQ-034 SUB a=0x05 b=0x05 then SUB a=0x03 b=0x04, back-to-back with out_ready=1 -> y=0x00 flag_z=1 flag_c=0; then y=0xFF flag_c=1; no idle cycle between.
REQ-035 MUL a=0xFF b=0xFF -> in_ready=0 for 8 cycles, out_valid at accept+9, y=0x01, y_hi=0xFE.
REQ-036 XOR a=0xA5 b=0x5A with out_ready=0 for 5 cycles -> y=0xFF held, out_valid held, in_ready=0 throughout; accept on 6th cycle.
REQ-037 MUL a=0x12 b=0x34, rst pulsed 3 cycles after accept -> out_valid never asserts; outputs 0; in_ready=1 after rst.
REQ-038 SHL a=0x81 b=0x01 -> y=0x02; SHR a=0x81 b=0x09 -> y=0x40 (shift amount masked to 1).
